// File: rtl/elevator_dispatcher.sv
// ============================================================================
// Module   : elevator_dispatcher
// Brief    : SCAN-policy request dispatcher that latches calls, tracks the car floor and
//            issues the 2-bit up/down motion command, with a timed door dwell per stop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_dispatcher #(
    parameter  int FLOORS      = 4,
    parameter  int DOOR_CYCLES = 8,
    localparam int FW          = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] call_req,
    input  logic              floor_step,
    output logic [1:0]        upDown,
    output logic [FW-1:0]     cur_floor,
    output logic [FLOORS-1:0] pending,
    output logic              door_open,
    output logic              fault
);

    localparam int          CW       = $clog2(DOOR_CYCLES + 1);
    localparam logic [CW-1:0] C_DLOAD = CW'(DOOR_CYCLES - 1);
    localparam logic [FW-1:0] C_TOP   = FW'(FLOORS - 1);
    localparam logic [1:0]  C_STOP   = 2'b00;
    localparam logic [1:0]  C_UP     = 2'b01;
    localparam logic [1:0]  C_DOWN   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR      = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FW-1:0]     r_floor;
    logic [FW-1:0]     w_floor_nxt;
    logic [FLOORS-1:0] r_pending;
    logic [FLOORS-1:0] w_clear;
    logic              r_dir_up;
    logic              w_dir_up_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              r_fault;
    logic              w_fault_nxt;
    logic [1:0]        r_updown;
    logic [1:0]        w_updown_nxt;
    logic              r_door;
    logic [FW-1:0]     w_floor_inc;
    logic [FW-1:0]     w_floor_dec;

    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic res;
        res = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (i > int'(f))) res = 1'b1;
        end
        return res;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic res;
        res = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (i < int'(f))) res = 1'b1;
        end
        return res;
    endfunction

    assign w_floor_inc = r_floor + 1'b1;
    assign w_floor_dec = r_floor - 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_cnt_nxt    = r_cnt;
        w_fault_nxt  = r_fault;
        w_dir_up_nxt = r_dir_up;
        w_updown_nxt = C_STOP;
        w_clear      = '0;

        case (r_state)
            S_IDLE: begin
                if (floor_step) w_fault_nxt = 1'b1;
                if (r_pending != '0) begin
                    if (r_pending[r_floor])
                        w_state_nxt = S_DOOR;
                    else if (r_dir_up)
                        w_state_nxt = any_above(r_pending, r_floor) ? S_MOVE_UP : S_MOVE_DOWN;
                    else
                        w_state_nxt = any_below(r_pending, r_floor) ? S_MOVE_DOWN : S_MOVE_UP;
                end
            end
            S_MOVE_UP: begin
                if (floor_step) begin
                    if (r_floor == C_TOP) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_floor_nxt = w_floor_inc;
                        if (r_pending[w_floor_inc])
                            w_state_nxt = S_DOOR;
                        else if (!any_above(r_pending, w_floor_inc))
                            w_state_nxt = S_IDLE;
                    end
                end
            end
            S_MOVE_DOWN: begin
                if (floor_step) begin
                    if (r_floor == '0) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_floor_nxt = w_floor_dec;
                        if (r_pending[w_floor_dec])
                            w_state_nxt = S_DOOR;
                        else if (!any_below(r_pending, w_floor_dec))
                            w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                if (floor_step) w_fault_nxt = 1'b1;
                if (r_cnt == '0)
                    w_state_nxt = S_IDLE;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
        endcase

        // Dwell timer is loaded only on the entering edge, so re-presses cannot extend it.
        if (w_state_nxt == S_DOOR && r_state != S_DOOR)
            w_cnt_nxt = C_DLOAD;

        // The serviced floor is masked on entry and throughout the dwell.
        if (w_state_nxt == S_DOOR || r_state == S_DOOR)
            w_clear = FLOORS'(1) << w_floor_nxt;

        if (w_state_nxt == S_MOVE_UP) begin
            w_updown_nxt = C_UP;
            w_dir_up_nxt = 1'b1;
        end else if (w_state_nxt == S_MOVE_DOWN) begin
            w_updown_nxt = C_DOWN;
            w_dir_up_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_floor   <= '0;
            r_pending <= '0;
            r_dir_up  <= 1'b1;
            r_cnt     <= '0;
            r_fault   <= 1'b0;
            r_updown  <= C_STOP;
            r_door    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_floor   <= w_floor_nxt;
            r_pending <= (r_pending | call_req) & ~w_clear;
            r_dir_up  <= w_dir_up_nxt;
            r_cnt     <= w_cnt_nxt;
            r_fault   <= w_fault_nxt;
            r_updown  <= w_updown_nxt;
            r_door    <= (w_state_nxt == S_DOOR);
        end
    end

    assign upDown    = r_updown;
    assign cur_floor = r_floor;
    assign pending   = r_pending;
    assign door_open = r_door;
    assign fault     = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_elevator_dispatcher.sv
// ============================================================================
// Module   : tb_elevator_dispatcher
// Brief    : Directed self-checking bench for elevator_dispatcher (FLOORS=4, DOOR_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elevator_dispatcher;

    localparam int FLOORS      = 4;
    localparam int DOOR_CYCLES = 4;
    localparam int FW          = $clog2(FLOORS);

    logic              clk;
    logic              rst;
    logic [FLOORS-1:0] call_req;
    logic              floor_step;
    logic [1:0]        upDown;
    logic [FW-1:0]     cur_floor;
    logic [FLOORS-1:0] pending;
    logic              door_open;
    logic              fault;

    int checks;
    int errors;

    elevator_dispatcher #(
        .FLOORS      (FLOORS),
        .DOOR_CYCLES (DOOR_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .call_req   (call_req),
        .floor_step (floor_step),
        .upDown     (upDown),
        .cur_floor  (cur_floor),
        .pending    (pending),
        .door_open  (door_open),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        call_req   = '0;
        floor_step = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic step_once();
        floor_step = 1'b1;
        tick();
        floor_step = 1'b0;
    endtask

    task automatic press(input logic [FLOORS-1:0] v);
        call_req = v;
        tick();
        call_req = '0;
    endtask

    // Called while door_open is first seen high; returns after door closes.
    task automatic wait_door(input string name);
        int n;
        n = 0;
        while (door_open && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n !== DOOR_CYCLES) begin
            errors++;
            $display("FAIL %s: door_open cycles actual=%0d required=%0d", name, n, DOOR_CYCLES);
        end
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (upDown !== 2'b00 || cur_floor !== '0 || pending !== '0 ||
                door_open !== 1'b0 || fault !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_stable: unstable cycles actual=%0d required=0", bad);
        end
        checks++;
        if (upDown !== 2'b00) begin
            errors++;
            $display("FAIL reset_updown: actual=%b required=00", upDown);
        end
        checks++;
        if (pending !== 4'b0000 || cur_floor !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: pending=%b floor=%0d required 0000/0", pending, cur_floor);
        end
    endtask

    task automatic test_basic_trip();
        call_req = 4'b0100;
        tick();
        call_req = '0;
        checks++;
        if (pending !== 4'b0100 || upDown !== 2'b00) begin
            errors++;
            $display("FAIL trip_latch: pending=%b upDown=%b required 0100/00", pending, upDown);
        end
        tick();
        checks++;
        if (upDown !== 2'b01) begin
            errors++;
            $display("FAIL trip_cmd: upDown actual=%b required=01", upDown);
        end
        step_once();
        checks++;
        if (cur_floor !== 2'd1 || upDown !== 2'b01) begin
            errors++;
            $display("FAIL trip_pass1: floor=%0d upDown=%b required 1/01", cur_floor, upDown);
        end
        step_once();
        checks++;
        if (cur_floor !== 2'd2 || door_open !== 1'b1 || pending !== 4'b0000 || upDown !== 2'b00) begin
            errors++;
            $display("FAIL trip_arrive: floor=%0d door=%b pending=%b upDown=%b required 2/1/0000/00",
                     cur_floor, door_open, pending, upDown);
        end
        wait_door("trip_dwell");
        checks++;
        if (upDown !== 2'b00 || door_open !== 1'b0) begin
            errors++;
            $display("FAIL trip_after: upDown=%b door=%b required 00/0", upDown, door_open);
        end
    endtask

    task automatic test_same_floor();
        int n;
        int bad;
        do_reset();
        press(4'b0001);
        tick();
        checks++;
        if (door_open !== 1'b1 || cur_floor !== 2'd0 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL same_enter: door=%b floor=%0d pending=%b required 1/0/0000",
                     door_open, cur_floor, pending);
        end
        n = 0;
        bad = 0;
        while (door_open && n < 20) begin
            n++;
            call_req = (n == 2) ? 4'b0001 : 4'b0000;
            if (upDown !== 2'b00) bad++;
            tick();
        end
        call_req = '0;
        checks++;
        if (n !== DOOR_CYCLES || bad !== 0) begin
            errors++;
            $display("FAIL same_absorb: cycles=%0d moving=%0d required %0d/0", n, bad, DOOR_CYCLES);
        end
        tick();
        checks++;
        if (pending !== 4'b0000 || door_open !== 1'b0) begin
            errors++;
            $display("FAIL same_after: pending=%b door=%b required 0000/0", pending, door_open);
        end
    endtask

    task automatic test_scan();
        do_reset();
        press(4'b1000);
        tick();
        step_once();
        press(4'b0101);
        checks++;
        if (pending !== 4'b1101 || upDown !== 2'b01 || cur_floor !== 2'd1) begin
            errors++;
            $display("FAIL scan_setup: pending=%b upDown=%b floor=%0d required 1101/01/1",
                     pending, upDown, cur_floor);
        end
        step_once();
        checks++;
        if (cur_floor !== 2'd2 || door_open !== 1'b1 || pending !== 4'b1001) begin
            errors++;
            $display("FAIL scan_stop2: floor=%0d door=%b pending=%b required 2/1/1001",
                     cur_floor, door_open, pending);
        end
        wait_door("scan_dwell2");
        tick();
        checks++;
        if (upDown !== 2'b01) begin
            errors++;
            $display("FAIL scan_resume_up: upDown actual=%b required=01", upDown);
        end
        step_once();
        checks++;
        if (cur_floor !== 2'd3 || door_open !== 1'b1 || pending !== 4'b0001) begin
            errors++;
            $display("FAIL scan_stop3: floor=%0d door=%b pending=%b required 3/1/0001",
                     cur_floor, door_open, pending);
        end
        wait_door("scan_dwell3");
        tick();
        checks++;
        if (upDown !== 2'b10) begin
            errors++;
            $display("FAIL scan_reverse: upDown actual=%b required=10", upDown);
        end
        step_once();
        step_once();
        checks++;
        if (cur_floor !== 2'd1 || upDown !== 2'b10 || door_open !== 1'b0) begin
            errors++;
            $display("FAIL scan_descend: floor=%0d upDown=%b door=%b required 1/10/0",
                     cur_floor, upDown, door_open);
        end
        step_once();
        checks++;
        if (cur_floor !== 2'd0 || door_open !== 1'b1 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL scan_stop0: floor=%0d door=%b pending=%b required 0/1/0000",
                     cur_floor, door_open, pending);
        end
        wait_door("scan_dwell0");
    endtask

    task automatic test_idle_step_fault();
        do_reset();
        press(4'b0010);
        tick();
        step_once();
        wait_door("fault_dwell");
        checks++;
        if (fault !== 1'b0 || cur_floor !== 2'd1) begin
            errors++;
            $display("FAIL fault_pre: fault=%b floor=%0d required 0/1", fault, cur_floor);
        end
        step_once();
        checks++;
        if (fault !== 1'b1 || cur_floor !== 2'd1) begin
            errors++;
            $display("FAIL fault_set: fault=%b floor=%0d required 1/1", fault, cur_floor);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky: fault actual=%b required=1", fault);
        end
        do_reset();
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: fault actual=%b required=0", fault);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(4'b0100);
        tick();
        step_once();
        step_once();
        wait_door("areset_dwell");
        press(4'b0001);
        tick();
        press(4'b1000);
        checks++;
        if (upDown !== 2'b10 || pending !== 4'b1001 || cur_floor !== 2'd2) begin
            errors++;
            $display("FAIL areset_setup: upDown=%b pending=%b floor=%0d required 10/1001/2",
                     upDown, pending, cur_floor);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (upDown !== 2'b00 || pending !== 4'b0000 || cur_floor !== 2'd0) begin
            errors++;
            $display("FAIL areset_immediate: upDown=%b pending=%b floor=%0d required 00/0000/0",
                     upDown, pending, cur_floor);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        call_req   = '0;
        floor_step = 1'b0;
        test_reset();
        test_basic_trip();
        test_same_floor();
        test_scan();
        test_idle_step_fault();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
